// File: rtl/add6_arbiter.sv
// add6_arbiter: two-client round-robin sequencer that performs 6-bit additions
// on a shared 3-bit ripple-carry adder in three fixed passes (low, high, carry fold).

// 3-bit ripple-carry adder, no carry-in; purely combinational.
module add6_arbiter_adder3 (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [2:0] sum_o,
  output logic       cout_o
);

  logic [3:0] carry;

  // Ripple the carry from bit 0 (LSB) upward.
  always_comb begin
    carry    = 4'b0000;
    sum_o    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[3];
  end

endmodule

module add6_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [5:0] a0,
  input  logic [5:0] b0,
  input  logic       req1,
  input  logic [5:0] a1,
  input  logic [5:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [5:0] sum,
  output logic       cout,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LO, HI, CARRY, DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [5:0] a_q, a_d;
  logic [5:0] b_q, b_d;
  logic [2:0] sum_lo_q, sum_lo_d;
  logic       c_lo_q, c_lo_d;
  logic [2:0] raw_hi_q, raw_hi_d;
  logic       c_hi_q, c_hi_d;
  logic [5:0] sum_q, sum_d;
  logic       cout_q, cout_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;

  logic [2:0] add_a, add_b, add_sum;
  logic       add_cout;
  logic       grant1;

  add6_arbiter_adder3 u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Steer the shared adder operands according to which pass is running.
  always_comb begin
    add_a = 3'b000;
    add_b = 3'b000;
    case (state_q)
      LO: begin
        add_a = a_q[2:0];
        add_b = b_q[2:0];
      end
      HI: begin
        add_a = a_q[5:3];
        add_b = b_q[5:3];
      end
      CARRY: begin
        add_a = raw_hi_q;
        add_b = {2'b00, c_lo_q};
      end
      default: ;
    endcase
  end

  // Round-robin pick: client 1 wins alone, or on a tie when client 0 was served last.
  always_comb begin
    grant1 = req1 & (~req0 | ~last_q);
  end

  // Next-state and registered-output logic for the five-state sequencer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_lo_d = sum_lo_q;
    c_lo_d   = c_lo_q;
    raw_hi_d = raw_hi_q;
    c_hi_d   = c_hi_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = grant1;
          last_d  = grant1;
          a_d     = grant1 ? a1 : a0;
          b_d     = grant1 ? b1 : b0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          state_d = LO;
        end
      end
      LO: begin
        sum_lo_d = add_sum;
        c_lo_d   = add_cout;
        state_d  = HI;
      end
      HI: begin
        raw_hi_d = add_sum;
        c_hi_d   = add_cout;
        state_d  = CARRY;
      end
      CARRY: begin
        sum_d   = {add_sum, sum_lo_q};
        cout_d  = c_hi_q | add_cout;
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation and re-arms the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      a_q      <= 6'd0;
      b_q      <= 6'd0;
      sum_lo_q <= 3'd0;
      c_lo_q   <= 1'b0;
      raw_hi_q <= 3'd0;
      c_hi_q   <= 1'b0;
      sum_q    <= 6'd0;
      cout_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_lo_q <= sum_lo_d;
      c_lo_q   <= c_lo_d;
      raw_hi_q <= raw_hi_d;
      c_hi_q   <= c_hi_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_add6_arbiter.sv
// Self-checking bench for add6_arbiter: scoreboard of expected (owner, {cout,sum})
// pushed when a request is driven, popped whenever a done pulse appears.
module tb_add6_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [5:0] a0, b0, a1, b1;
  logic       ack0, ack1, done0, done1, cout, busy;
  logic [5:0] sum;

  typedef struct {
    bit         owner;
    logic [6:0] val;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   ackCyc     = 0;

  add6_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .ack0  (ack0),
    .ack1  (ack1),
    .done0 (done0),
    .done1 (done1),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy)
  );

  // 10 ns clock; rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure ack-to-done and ack-to-ack spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (ack0 === 1'b1 || ack1 === 1'b1) ackCyc = cyc;
    if (ack0 === 1'b1 && ack1 === 1'b1) begin
      compared++; mismatched++;
      $display("[TB] FAIL dual_ack: ack0=%b ack1=%b, required one-hot", ack0, ack1);
    end
    if (done0 === 1'b1 || done1 === 1'b1) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_done: done0=%b done1=%b with no outstanding request", done0, done1);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ({done1, done0} !== (e.owner ? 2'b10 : 2'b01)) begin
          mismatched++;
          $display("[TB] FAIL done_owner: got done1/done0=%b%b, required owner %0d", done1, done0, e.owner);
        end
        compared++;
        if ({cout, sum} !== e.val) begin
          mismatched++;
          $display("[TB] FAIL result: got 0x%0h, required 0x%0h", {cout, sum}, e.val);
        end
        compared++;
        if (cyc - ackCyc !== 3) begin
          mismatched++;
          $display("[TB] FAIL latency: got %0d cycles ack->done, required 3", cyc - ackCyc);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({ack0, ack1, done0, done1, sum, cout, busy} !== 12'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b, required all zero",
               {ack0, ack1, done0, done1, sum, cout, busy});
    end
  endtask

  // One isolated operation from IDLE; checks ack at T+1 and busy over T+1..T+5.
  task automatic run_single(input bit cl, input logic [5:0] a, input logic [5:0] b);
    int  n;
    bit  got;
    exp_t e;
    e.owner = cl;
    e.val   = {1'b0, a} + {1'b0, b};
    expQ.push_back(e);
    if (cl) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if ((cl ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    compared++;
    if (!got || n != 1) begin
      mismatched++;
      $display("[TB] FAIL ack_timing: client %0d ack after %0d cycles (seen=%0d), required 1", cl, n, got);
    end
    compared++;
    if ((cl ? ack0 : ack1) !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ack_cycle: other ack=%b busy=%b, required 0 and 1", cl ? ack0 : ack1, busy);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      compared++;
      if (busy !== (k < 4)) begin
        mismatched++;
        $display("[TB] FAIL busy: cycle T+%0d busy=%b, required %b", k + 1, busy, k < 4);
      end
    end
  endtask

  task automatic test_client0_alone;
    run_single(1'b0, 6'h15, 6'h0E);
  endtask

  task automatic test_carry_fold;
    run_single(1'b1, 6'h07, 6'h01);
    run_single(1'b1, 6'h3F, 6'h01);
    run_single(1'b1, 6'h38, 6'h08);
  endtask

  task automatic test_back_to_back;
    logic [5:0] op0a[2], op0b[2], op1a[2], op1b[2];
    exp_t e;
    int   lastAck;
    bit   got;
    op0a = '{6'h11, 6'h2C}; op0b = '{6'h05, 6'h3A};
    op1a = '{6'h30, 6'h09}; op1b = '{6'h22, 6'h1F};
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      e.owner = g[0];
      e.val   = g[0] ? ({1'b0, op1a[g/2]} + {1'b0, op1b[g/2]})
                     : ({1'b0, op0a[g/2]} + {1'b0, op0b[g/2]});
      expQ.push_back(e);
    end
    a0 = op0a[0]; b0 = op0b[0]; a1 = op1a[0]; b1 = op1b[0];
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    lastAck = 0;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int n = 0; n < 30 && !got; n++) begin
        @(negedge clk);
        if (ack0 === 1'b1 || ack1 === 1'b1) got = 1'b1;
      end
      compared++;
      if (!got || ack1 !== g[0]) begin
        mismatched++;
        $display("[TB] FAIL rr_order: grant %0d seen=%0d ack1=%b, required client %0d", g, got, ack1, g[0]);
      end
      if (g > 0) begin
        compared++;
        if (cyc - lastAck !== 5) begin
          mismatched++;
          $display("[TB] FAIL rr_spacing: grant %0d after %0d cycles, required 5", g, cyc - lastAck);
        end
      end
      lastAck = cyc;
      case (g)
        0: begin a0 = op0a[1]; b0 = op0b[1]; end
        1: begin a1 = op1a[1]; b1 = op1b[1]; end
        2: req0 = 1'b0;
        default: req1 = 1'b0;
      endcase
    end
    for (int n = 0; n < 30 && expQ.size() != 0; n++) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rr_drain: %0d results outstanding, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_operand_change;
    exp_t e;
    bit   got;
    e.owner = 1'b0;
    e.val   = {1'b0, 6'h2A} + {1'b0, 6'h11};
    expQ.push_back(e);
    a0 = 6'h2A; b0 = 6'h11; req0 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1) got = 1'b1;
    end
    req0 = 1'b0;
    @(posedge clk);
    #1 a0 = 6'h01; b0 = 6'h3E;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
    compared++;
    if (!got || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL operand_change: ack seen=%0d outstanding=%0d, required 1 and 0", got, expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    exp_t e;
    bit   got;
    bit   sawDone;
    a1 = 6'h05; b1 = 6'h06; req1 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack1 === 1'b1) got = 1'b1;
    end
    req1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (!got || {ack0, ack1, done0, done1, sum, cout, busy} !== 12'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: ack seen=%0d outputs=%b, required 1 and all zero", got,
               {ack0, ack1, done0, done1, sum, cout, busy});
    end
    sawDone = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done1 === 1'b1) sawDone = 1'b1;
    end
    compared++;
    if (sawDone) begin
      mismatched++;
      $display("[TB] FAIL reset_abort: done1 seen=%0d, required 0", sawDone);
    end
    e.owner = 1'b0; e.val = {1'b0, 6'h0A} + {1'b0, 6'h0B}; expQ.push_back(e);
    e.owner = 1'b1; e.val = {1'b0, 6'h33} + {1'b0, 6'h1D}; expQ.push_back(e);
    a0 = 6'h0A; b0 = 6'h0B; a1 = 6'h33; b1 = 6'h1D;
    req0 = 1'b1; req1 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) got = 1'b1;
    end
    compared++;
    if (!got || ack0 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_pointer: ack0=%b ack1=%b, required client 0 first", ack0, ack1);
    end
    req0 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack1 === 1'b1) got = 1'b1;
    end
    req1 = 1'b0;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
    compared++;
    if (!got || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_drain: ack1 seen=%0d outstanding=%0d, required 1 and 0", got, expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_sweep;
    for (int i = 0; i < 2000; i++) begin
      run_single(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sweep_drain: %0d results outstanding, required 0", expQ.size());
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset;
    test_client0_alone;
    test_carry_fold;
    test_back_to_back;
    test_operand_change;
    test_reset_mid_op;
    test_random_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
